// File: rtl/fetch_pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_pc_unit                                                |
// | Description : Program counter plus IF/ID pipeline register around a        |
// |               combinational instruction memory. Supports hazard stall,     |
// |               branch/jump redirect with IF/ID flush, and a HALT state      |
// |               entered after the program-end address has been fetched.     |
// |                                                                            |
// | Ports                                                                      |
// |   clk               in   rising-edge clock                                 |
// |   rst_n             in   asynchronous active-low reset                     |
// |   Stall             in   hold PC and IF/ID                                 |
// |   Branch_Taken      in   redirect request, flushes IF/ID                   |
// |   Branch_Target     in   [31:0] redirect address (bits [1:0] ignored)      |
// |   Instruction       in   [31:0] memory word addressed by PC_out            |
// |   PC_out            out  [31:0] current fetch address                      |
// |   IF_ID_Instruction out  [31:0] registered instruction for decode          |
// |   IF_ID_PC          out  [31:0] registered address of that instruction     |
// |   IF_ID_Valid       out  IF/ID holds a real instruction                    |
// |   Halted            out  stage is in HALT                                  |
// |   Fetch_Count       out  [31:0] fetches loaded into IF/ID (optional)       |
// |   Stall_Count       out  [31:0] stalled RUN cycles (optional)              |
// |                                                                            |
// | Build option: define FETCH_PERF_CNT_EN to implement the two performance   |
// |               counters; otherwise both count ports are constant zero.      |
// |                                                                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] PROG_END = 32'd24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic [31:0] Instruction,
  output logic [31:0] PC_out,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC,
  output logic        IF_ID_Valid,
  output logic        Halted,
  output logic [31:0] Fetch_Count,
  output logic [31:0] Stall_Count
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [31:0] C_NOP = 32'd0;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;

  // Decoded edge actions, shared by the next-state logic and the counters.
  logic w_fetch_load;   // RUN, no branch, no stall: a real instruction enters IF/ID
  logic w_stall_run;    // RUN, stall honoured, no branch
  logic w_at_end;       // current fetch address is the last program word

  // Redirect targets are word aligned; the low two address bits are dropped.
  logic [1:0] w_unused_tgt_bits;
  assign w_unused_tgt_bits = Branch_Target[1:0];

  assign w_fetch_load = !Branch_Taken && !Stall && (state_q == ST_RUN);
  assign w_stall_run  = !Branch_Taken &&  Stall && (state_q == ST_RUN);
  assign w_at_end     = (pc_q == PROG_END);

  // Next-state logic. Priority: redirect, then stall, then state action.
  always_comb begin
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    state_d      = state_q;

    if (Branch_Taken) begin
      // Redirect always wins, including out of HALT and over a stall.
      pc_d         = {Branch_Target[31:2], 2'b00};
      ifid_instr_d = C_NOP;
      ifid_pc_d    = 32'd0;
      ifid_valid_d = 1'b0;
      state_d      = ST_RUN;
    end else if (Stall) begin
      // Everything holds; in HALT the IF/ID bubble simply persists.
    end else begin
      case (state_q)
        ST_RUN: begin
          ifid_instr_d = Instruction;
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b1;
          if (w_at_end) begin
            // Last word captured: park the PC on it and stop fetching.
            state_d = ST_HALT;
          end else begin
            pc_d = pc_q + PC_STEP;  // wraps naturally at 2^32
          end
        end
        ST_HALT: begin
          ifid_instr_d = C_NOP;
          ifid_pc_d    = 32'd0;
          ifid_valid_d = 1'b0;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      ifid_instr_q <= C_NOP;
      ifid_pc_q    <= 32'd0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign PC_out            = pc_q;
  assign IF_ID_Instruction = ifid_instr_q;
  assign IF_ID_PC          = ifid_pc_q;
  assign IF_ID_Valid       = ifid_valid_q;
  assign Halted            = (state_q == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (w_fetch_load) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    // Stalls while halted are not counted: nothing was being fetched.
    if (w_stall_run) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Fetch_Count = fetch_cnt_q;
  assign Stall_Count = stall_cnt_q;
`else
  // Counters not built: the decoded strobes have no consumer.
  logic w_unused_cnt_strobes;
  assign w_unused_cnt_strobes = w_fetch_load ^ w_stall_run;

  assign Fetch_Count = 32'd0;
  assign Stall_Count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_pc_unit                                             |
// | Description : Directed scoreboard bench for fetch_pc_unit. Stimulus pushes |
// |               hand-computed expected outputs; a monitor pops and compares. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_fetch_pc_unit;

  localparam logic [31:0] C_RESET_PC = 32'd0;
  localparam logic [31:0] C_PC_STEP  = 32'd4;
  localparam logic [31:0] C_PROG_END = 32'd24;

  logic        clk;
  logic        rst_n;
  logic        Stall;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic [31:0] Instruction;
  logic [31:0] PC_out;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PC;
  logic        IF_ID_Valid;
  logic        Halted;
  logic [31:0] Fetch_Count;
  logic [31:0] Stall_Count;

  fetch_pc_unit #(
    .RESET_PC (C_RESET_PC),
    .PC_STEP  (C_PC_STEP),
    .PROG_END (C_PROG_END)
  ) u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .Stall             (Stall),
    .Branch_Taken      (Branch_Taken),
    .Branch_Target     (Branch_Target),
    .Instruction       (Instruction),
    .PC_out            (PC_out),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_PC          (IF_ID_PC),
    .IF_ID_Valid       (IF_ID_Valid),
    .Halted            (Halted),
    .Fetch_Count       (Fetch_Count),
    .Stall_Count       (Stall_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: two fixed words, everything else address-tagged.
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'd0:   imem = 32'h0022_0000;
      32'd4:   imem = 32'h0064_0000;
      default: imem = 32'hA500_0000 ^ a;
    endcase
  endfunction

  assign Instruction = imem(PC_out);

  // Counter expectations collapse to zero when the counters are not built.
  function automatic logic [31:0] cnt(input int x);
`ifdef FETCH_PERF_CNT_EN
    cnt = 32'(x);
`else
    cnt = 32'd0;
`endif
  endfunction

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] ifi;
    logic [31:0] ifpc;
    logic        v;
    logic        h;
    logic [31:0] fc;
    logic [31:0] sc;
  } exp_t;

  exp_t q[$];
  event smp;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input string fld,
                     input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", tag, fld, act, req);
    end
  endtask

  // Monitor: every sample point pops one expectation and checks all outputs.
  initial begin
    exp_t e;
    forever begin
      @(smp);
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: sample with no expectation queued, got 0 expected 1");
      end else begin
        e = q.pop_front();
        chk(e.tag, "PC_out", PC_out, e.pc);
        chk(e.tag, "IF_ID_Instruction", IF_ID_Instruction, e.ifi);
        chk(e.tag, "IF_ID_PC", IF_ID_PC, e.ifpc);
        chk(e.tag, "IF_ID_Valid", {31'd0, IF_ID_Valid}, {31'd0, e.v});
        chk(e.tag, "Halted", {31'd0, Halted}, {31'd0, e.h});
        chk(e.tag, "Fetch_Count", Fetch_Count, e.fc);
        chk(e.tag, "Stall_Count", Stall_Count, e.sc);
      end
    end
  end

  task automatic push(input string tag, input logic [31:0] pc, input logic [31:0] ifi,
                      input logic [31:0] ifpc, input logic v, input logic h,
                      input int fc, input int sc);
    exp_t e;
    e.tag  = tag;
    e.pc   = pc;
    e.ifi  = ifi;
    e.ifpc = ifpc;
    e.v    = v;
    e.h    = h;
    e.fc   = cnt(fc);
    e.sc   = cnt(sc);
    q.push_back(e);
  endtask

  // One clock edge with the given inputs, followed by a sample of the result.
  task automatic step(input logic st, input logic br, input logic [31:0] tgt,
                      input string tag, input logic [31:0] pc, input logic [31:0] ifi,
                      input logic [31:0] ifpc, input logic v, input logic h,
                      input int fc, input int sc);
    Stall         = st;
    Branch_Taken  = br;
    Branch_Target = tgt;
    push(tag, pc, ifi, ifpc, v, h, fc, sc);
    @(posedge clk);
    #1;
    -> smp;
  endtask

  initial begin
    rst_n         = 1'b0;
    Stall         = 1'b0;
    Branch_Taken  = 1'b0;
    Branch_Target = 32'd0;

    #3;
    push("reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 0, 0);
    -> smp;
    @(negedge clk);
    rst_n = 1'b1;

    //   st    br    target            tag          PC_out        IF_ID_Instr          IF_ID_PC      V     H     fc  sc
    step(1'b0, 1'b0, 32'd0,          "fetch0",     32'd4,        32'h0022_0000,       32'd0,        1'b1, 1'b0, 1,  0);
    step(1'b0, 1'b0, 32'd0,          "fetch4",     32'd8,        32'h0064_0000,       32'd4,        1'b1, 1'b0, 2,  0);
    step(1'b1, 1'b0, 32'd0,          "stall1",     32'd8,        32'h0064_0000,       32'd4,        1'b1, 1'b0, 2,  1);
    step(1'b1, 1'b0, 32'd0,          "stall2",     32'd8,        32'h0064_0000,       32'd4,        1'b1, 1'b0, 2,  2);
    step(1'b1, 1'b0, 32'd0,          "stall3",     32'd8,        32'h0064_0000,       32'd4,        1'b1, 1'b0, 2,  3);
    step(1'b0, 1'b0, 32'd0,          "fetch8",     32'd12,       32'hA500_0008,       32'd8,        1'b1, 1'b0, 3,  3);
    step(1'b1, 1'b1, 32'h0000_000E,  "br_stall",   32'h0000_000C, 32'd0,              32'd0,        1'b0, 1'b0, 3,  3);
    step(1'b0, 1'b0, 32'd0,          "fetchC",     32'd16,       32'hA500_000C,       32'd12,       1'b1, 1'b0, 4,  3);
    step(1'b0, 1'b0, 32'd0,          "fetch16",    32'd20,       32'hA500_0010,       32'd16,       1'b1, 1'b0, 5,  3);
    step(1'b0, 1'b0, 32'd0,          "fetch20",    32'd24,       32'hA500_0014,       32'd20,       1'b1, 1'b0, 6,  3);
    step(1'b0, 1'b0, 32'd0,          "fetch_end",  32'd24,       32'hA500_0018,       32'd24,       1'b1, 1'b1, 7,  3);
    step(1'b0, 1'b0, 32'd0,          "halt_bub",   32'd24,       32'd0,               32'd0,        1'b0, 1'b1, 7,  3);
    step(1'b1, 1'b0, 32'd0,          "halt_stall", 32'd24,       32'd0,               32'd0,        1'b0, 1'b1, 7,  3);
    step(1'b0, 1'b1, 32'd0,          "halt_br",    32'd0,        32'd0,               32'd0,        1'b0, 1'b0, 7,  3);
    step(1'b0, 1'b0, 32'd0,          "refetch0",   32'd4,        32'h0022_0000,       32'd0,        1'b1, 1'b0, 8,  3);
    step(1'b0, 1'b1, 32'hFFFF_FFFC,  "br_top",     32'hFFFF_FFFC, 32'd0,              32'd0,        1'b0, 1'b0, 8,  3);
    step(1'b0, 1'b0, 32'd0,          "wrap",       32'd0,        32'h5AFF_FFFC,       32'hFFFF_FFFC, 1'b1, 1'b0, 9, 3);
    step(1'b0, 1'b1, 32'd24,         "br_end",     32'd24,       32'd0,               32'd0,        1'b0, 1'b0, 9,  3);
    step(1'b0, 1'b0, 32'd0,          "br_end_ft",  32'd24,       32'hA500_0018,       32'd24,       1'b1, 1'b1, 10, 3);
    step(1'b0, 1'b1, 32'd8,          "br_8",       32'd8,        32'd0,               32'd0,        1'b0, 1'b0, 10, 3);
    step(1'b0, 1'b0, 32'd0,          "fetch8b",    32'd12,       32'hA500_0008,       32'd8,        1'b1, 1'b0, 11, 3);

    // Asynchronous reset between edges: outputs must clear without a clock.
    #2;
    rst_n = 1'b0;
    #1;
    push("async_rst", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 0, 0);
    -> smp;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 32'd0,          "post_rst",   32'd4,        32'h0022_0000,       32'd0,        1'b1, 1'b0, 1,  0);

    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
